// File: rtl/eif_pkg.sv
// Shared definitions for the EIF neuron scheduler.
//   sched_state_t   : sweep FSM encoding
//   THR_*_DEF       : default threshold-adaptation constants
//   idx_width()     : neuron-index width for a given neuron count
package eif_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE,
        S_DONE
    } sched_state_t;

    localparam int unsigned THR_INIT_DEF = 200;
    localparam int unsigned THR_DEC_DEF  = 10;
    localparam int unsigned THR_INC_DEF  = 1;
    localparam int unsigned THR_MIN_DEF  = 20;
    localparam int unsigned THR_MAX_DEF  = 250;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eif_neuron_scheduler_if.sv
// Handshake bundle between stimulus front-end, scheduler and spike consumer.
//   start/busy/done               : timestep control
//   cur_valid/cur_ready/cur_data  : input current stream, one word per neuron idx
//   idx                           : neuron currently being served
//   spk_valid/spk_ready/spk_id    : spike-event stream (FIFO head)
// master = environment side, slave = scheduler side.
interface eif_neuron_scheduler_if
    import eif_pkg::*;
#(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned W         = 8
);
    localparam int unsigned IW = idx_width(N_NEURONS);

    logic          start;
    logic          busy;
    logic          done;
    logic          cur_valid;
    logic          cur_ready;
    logic [W-1:0]  cur_data;
    logic [IW-1:0] idx;
    logic          spk_valid;
    logic          spk_ready;
    logic [IW-1:0] spk_id;

    modport master (
        output start, cur_valid, cur_data, spk_ready,
        input  busy, done, cur_ready, idx, spk_valid, spk_id
    );

    modport slave (
        input  start, cur_valid, cur_data, spk_ready,
        output busy, done, cur_ready, idx, spk_valid, spk_id
    );

endinterface

// File: rtl/eif_neuron_scheduler_fifo.sv
// spike_event_fifo: synchronous FIFO for spike events.
//   clk, rst (sync, active-high)
//   push/din  : write; accepted when not full, or when full with a pop in the same cycle
//   pop/dout  : read; dout is the head, stable until popped
//   full/empty/count : occupancy
module spike_event_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/eif_neuron_scheduler.sv
// eif_neuron_scheduler: one adaptive-threshold EIF update datapath shared by
// N_NEURONS virtual neurons. A start pulse sweeps neurons 0..N-1; each neuron
// takes one current word (LOAD) and is updated (UPDATE); spiking neuron ids are
// queued in a FIFO for the downstream consumer.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : eif_neuron_scheduler_if.slave (start/busy/done, current stream,
//          idx, spike-event stream)
module eif_neuron_scheduler
    import eif_pkg::*;
#(
    parameter int unsigned N_NEURONS  = 8,
    parameter int unsigned W          = 8,
    parameter int unsigned THR_INIT   = THR_INIT_DEF,
    parameter int unsigned THR_DEC    = THR_DEC_DEF,
    parameter int unsigned THR_INC    = THR_INC_DEF,
    parameter int unsigned THR_MIN    = THR_MIN_DEF,
    parameter int unsigned THR_MAX    = THR_MAX_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    eif_neuron_scheduler_if.slave bus
);
    localparam int unsigned  IW   = idx_width(N_NEURONS);
    localparam int unsigned  CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

    sched_state_t  state;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  cur_q;
    logic          busy_q;
    logic          done_q;
    logic          cur_ready_q;

    logic [W-1:0]  v_mem   [N_NEURONS];
    logic [W-1:0]  thr_mem [N_NEURONS];

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [IW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [W-1:0]  s_cur;
    logic [W-1:0]  t_cur;
    logic [W:0]    v_sum;
    logic [W:0]    t_sum;
    logic [W-1:0]  v_next;
    logic [W-1:0]  thr_next;
    logic          spike;
    logic          stall;

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cur_ready = cur_ready_q;
    assign bus.idx       = idx_q;
    assign bus.spk_valid = !fifo_empty;
    assign bus.spk_id    = fifo_dout;

    assign fifo_pop  = !fifo_empty && bus.spk_ready;
    // A full FIFO only blocks the spike write-back if nothing leaves this cycle.
    assign stall     = (state == S_UPDATE) && spike && fifo_full && !fifo_pop;
    assign fifo_push = (state == S_UPDATE) && spike && !stall;

    // Neuron update: compare against the pre-update state, then either reset
    // and lower the threshold, or integrate (saturating) and raise it.
    always_comb begin
        s_cur    = v_mem[idx_q];
        t_cur    = thr_mem[idx_q];
        spike    = (s_cur >= t_cur);
        v_sum    = {1'b0, s_cur} + {1'b0, cur_q};
        t_sum    = {1'b0, t_cur} + (W+1)'(THR_INC);
        v_next   = '0;
        thr_next = t_cur;
        if (spike) begin
            v_next   = '0;
            thr_next = ({1'b0, t_cur} >= (W+1)'(THR_MIN + THR_DEC)) ? t_cur - W'(THR_DEC)
                                                                   : W'(THR_MIN);
        end else begin
            v_next   = v_sum[W] ? '1 : v_sum[W-1:0];
            thr_next = (t_sum > (W+1)'(THR_MAX)) ? W'(THR_MAX) : t_sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx_q       <= '0;
            cur_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cur_ready_q <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                v_mem[i]   <= '0;
                thr_mem[i] <= W'(THR_INIT);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_LOAD;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        cur_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.cur_valid && cur_ready_q) begin
                        cur_q       <= bus.cur_data;
                        cur_ready_q <= 1'b0;
                        state       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!stall) begin
                        v_mem[idx_q]   <= v_next;
                        thr_mem[idx_q] <= thr_next;
                        if (idx_q == LAST) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx_q       <= idx_q + IW'(1);
                            cur_ready_q <= 1'b1;
                            state       <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx_q  <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Occupancy flags and count must describe the same FIFO state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
            assert (fifo_empty == (fifo_count == '0));
        end
    end

    spike_event_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (idx_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_eif_neuron_scheduler.sv
// Self-checking bench for eif_neuron_scheduler (N=8, W=8, default thresholds).
module tb_eif_neuron_scheduler;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eif_neuron_scheduler_if #(.N_NEURONS(N), .W(8)) bus ();

    eif_neuron_scheduler #(
        .N_NEURONS  (N),
        .W          (8),
        .THR_INIT   (200),
        .THR_DEC    (10),
        .THR_INC    (1),
        .THR_MIN    (20),
        .THR_MAX    (250),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int spk_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.spk_valid === 1'b1 && bus.spk_ready === 1'b1)
            spk_q.push_back(int'(bus.spk_id));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit               do_rst;
        int               n;
        logic [7:0][7:0]  cur;
        logic [7:0]       exp_v;
        logic [7:0]       exp_thr;
        int               exp_spk;
        int               exp_id;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input bit r, input int n, input int c, input int ev,
                                   input int et, input int es, input int ei);
        vec_t v;
        v.do_rst  = r;
        v.n       = n;
        v.cur     = '0;
        v.cur[n]  = 8'(c);
        v.exp_v   = 8'(ev);
        v.exp_thr = 8'(et);
        v.exp_spk = es;
        v.exp_id  = ei;
        return v;
    endfunction

    function automatic int count_thr_ne(input int val);
        int c = 0;
        for (int i = 0; i < N; i++) if (dut.thr_mem[i] !== 8'(val)) c++;
        return c;
    endfunction

    function automatic int count_v_ne(input int val);
        int c = 0;
        for (int i = 0; i < N; i++) if (dut.v_mem[i] !== 8'(val)) c++;
        return c;
    endfunction

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic apply_reset();
        bus.start     = 1'b0;
        bus.cur_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        spk_q.delete();
    endtask

    task automatic start_sweep(output int t0);
        bus.start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic feed_one(input int i, input logic [7:0] d);
        int n = 0;
        bus.cur_data  = d;
        bus.cur_valid = 1'b1;
        @(negedge clk);
        while (bus.cur_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("cur_ready_n%0d", i), bus.cur_ready, 1);
        check($sformatf("idx_n%0d", i), bus.idx, i);
        check($sformatf("busy_n%0d", i), bus.busy, 1);
        @(posedge clk); #1;
        bus.cur_valid = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        int n = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
        check("busy_at_done", bus.busy, 1);
        lat = cyc - t0;
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pulse_1cyc", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
        @(posedge clk); #1;
    endtask

    // One timestep. gap_idx (>0, only from reset) holds cur_valid low 5 cycles
    // in that neuron's LOAD; mid_start pulses start during neuron 3's LOAD.
    task automatic run_ts(input logic [7:0][7:0] curs, input int gap_idx,
                          input bit mid_start, output int lat);
        int t0;
        start_sweep(t0);
        for (int i = 0; i < N; i++) begin
            if (i == gap_idx) begin
                @(posedge clk); #1;
                repeat (5) begin
                    @(negedge clk);
                    check("gap_cur_ready", bus.cur_ready, 1);
                    check("gap_idx", bus.idx, gap_idx);
                    check("gap_v_unchanged", dut.v_mem[gap_idx], 0);
                    check("gap_thr_unchanged", dut.thr_mem[gap_idx], 200);
                    @(posedge clk); #1;
                end
            end
            if (mid_start && i == 3) bus.start = 1'b1;
            feed_one(i, curs[i]);
            bus.start = 1'b0;
        end
        wait_done(t0, lat);
    endtask

    vec_t vecs[9];
    logic [7:0][7:0] zeros;
    logic [7:0][7:0] fulls;
    logic [7:0][7:0] mixed;
    int lat;
    int t0;

    initial begin
        bus.start     = 1'b0;
        bus.cur_valid = 1'b0;
        bus.cur_data  = '0;
        bus.spk_ready = 1'b1;
        zeros = '0;
        fulls = '1;
        mixed = {8{8'd5}};
        mixed[2] = 8'd77;

        // neuron 3 fed 50 every timestep; neuron 0 saturation then spike
        vecs[0] = mkvec(1, 3,  50,  50, 201, 0, 0);
        vecs[1] = mkvec(0, 3,  50, 100, 202, 0, 0);
        vecs[2] = mkvec(0, 3,  50, 150, 203, 0, 0);
        vecs[3] = mkvec(0, 3,  50, 200, 204, 0, 0);
        vecs[4] = mkvec(0, 3,  50, 250, 205, 0, 0);
        vecs[5] = mkvec(0, 3,  50,   0, 195, 1, 3);
        vecs[6] = mkvec(1, 0, 150, 150, 201, 0, 0);
        vecs[7] = mkvec(0, 0, 255, 255, 202, 0, 0);
        vecs[8] = mkvec(0, 0,   0,   0, 192, 1, 0);

        // reset state
        apply_reset();
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cur_ready", bus.cur_ready, 0);
        check("rst_spk_valid", bus.spk_valid, 0);
        check("rst_idx", bus.idx, 0);
        check("rst_thr_all200", count_thr_ne(200), 0);
        check("rst_v_all0", count_v_ne(0), 0);
        @(posedge clk); #1;

        // zero currents: no spikes, done 2N+1 after start
        run_ts(zeros, -1, 0, lat);
        check("t1_latency", lat, 17);
        check("t1_no_spikes", spk_q.size(), 0);

        // table-driven timesteps
        foreach (vecs[k]) begin
            if (vecs[k].do_rst) apply_reset();
            spk_q.delete();
            run_ts(vecs[k].cur, -1, 0, lat);
            check($sformatf("v%0d_latency", k), lat, 17);
            check($sformatf("v%0d_state", k), dut.v_mem[vecs[k].n], vecs[k].exp_v);
            check($sformatf("v%0d_thr", k), dut.thr_mem[vecs[k].n], vecs[k].exp_thr);
            check($sformatf("v%0d_nspk", k), spk_q.size(), vecs[k].exp_spk);
            if (vecs[k].exp_spk > 0 && spk_q.size() > 0)
                check($sformatf("v%0d_spk_id", k), spk_q[0], vecs[k].exp_id);
        end

        // threshold upper saturation
        apply_reset();
        repeat (55) run_ts(zeros, -1, 0, lat);
        check("thr_max_all250", count_thr_ne(250), 0);

        // threshold lower saturation: alternate integrate / spike
        apply_reset();
        spk_q.delete();
        repeat (30) begin
            run_ts(fulls, -1, 0, lat);
            run_ts(zeros, -1, 0, lat);
        end
        check("thr_min_all20", count_thr_ne(20), 0);
        check("thr_min_v_all0", count_v_ne(0), 0);
        check("thr_min_nspk", spk_q.size(), 240);

        // cur_valid gap at idx 2, start during sweep ignored
        apply_reset();
        run_ts(mixed, 2, 1, lat);
        check("t5_latency", lat, 22);
        check("t5_v2", dut.v_mem[2], 77);
        check("t5_v7", dut.v_mem[7], 5);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_queued_start", bus.busy, 0);
            @(posedge clk); #1;
        end

        // reset mid-UPDATE with queued events
        apply_reset();
        bus.spk_ready = 1'b1;
        run_ts(fulls, -1, 0, lat);
        bus.spk_ready = 1'b0;
        start_sweep(t0);
        for (int i = 0; i < 5; i++) feed_one(i, 8'd0);
        @(negedge clk);
        check("t6_pre_idx", bus.idx, 4);
        check("t6_pre_spk_valid", bus.spk_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", bus.busy, 0);
        check("t6_cur_ready", bus.cur_ready, 0);
        check("t6_spk_valid", bus.spk_valid, 0);
        check("t6_done", bus.done, 0);
        check("t6_idx", bus.idx, 0);
        check("t6_thr_all200", count_thr_ne(200), 0);
        check("t6_v_all0", count_v_ne(0), 0);
        @(posedge clk); #1;
        spk_q.delete();
        bus.spk_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("t6_events_lost", spk_q.size(), 0);

        // FIFO backpressure: stall at idx 4, then drain in order
        apply_reset();
        bus.spk_ready = 1'b1;
        run_ts(fulls, -1, 0, lat);
        spk_q.delete();
        bus.spk_ready = 1'b0;
        start_sweep(t0);
        for (int i = 0; i < 5; i++) feed_one(i, 8'd0);
        repeat (5) begin
            @(negedge clk);
            check("t4_stall_idx", bus.idx, 4);
            check("t4_stall_cur_ready", bus.cur_ready, 0);
            check("t4_stall_spk_valid", bus.spk_valid, 1);
            check("t4_stall_spk_id", bus.spk_id, 0);
            check("t4_stall_done", bus.done, 0);
            check("t4_stall_thr4", dut.thr_mem[4], 201);
            check("t4_stall_v4", dut.v_mem[4], 255);
            @(posedge clk); #1;
        end
        bus.spk_ready = 1'b1;
        for (int i = 5; i < N; i++) feed_one(i, 8'd0);
        wait_done(t0, lat);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_nspk", spk_q.size(), 8);
        for (int i = 0; i < N; i++)
            if (i < spk_q.size()) check($sformatf("t4_order%0d", i), spk_q[i], i);
        check("t4_thr_all191", count_thr_ne(191), 0);
        check("t4_spk_valid_end", bus.spk_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
